register: RTL and testbench

- 32-entry x 32-bit integer register file for the RISC-V core; x0 is hardwired to zero.
- Write-back port selects between the ALU result and memory load data.
- Three registered read outputs:
  - data1: operand A, indexed by rs1.
  - data2: operand B, indexed by rs2.
  - data3: store data, indexed by rs2.
- Sits between decode (register indices, enables) and execute/memory stages.

---
 rtl/regfile_pkg.sv | 36 +++
 rtl/regfile_array.sv | 53 +++++
 rtl/register.sv | 88 ++++++++
 tb/tb_register.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the integer register file of the RISC-V core.
//   Holds the data/index widths, the index of the hardwired zero register,
//   the write-back request bundle passed from the top to the storage array,
//   and a small helper that decides whether a destination index may be
//   written.
// ---------------------------------------------------------------------------
package regfile_pkg;

  // Data width of every architectural register and every data port.
  localparam int XLEN = 32;

  // Number of architectural registers (x0..x31).
  localparam int NREG = 32;

  // Index width, log2(NREG).
  localparam int AW = 5;

  // x0 is hardwired to zero: writes to it are dropped, reads return 0.
  localparam logic [AW-1:0] ZERO_REG = '0;

  // One write-back request as seen by the storage array. The source
  // selection (ALU result vs. load data) is already resolved into data.
  typedef struct packed {
    logic            en;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // A destination is writable only when it is not the zero register.
  function automatic logic is_writable(input logic [AW-1:0] idx);
    return idx != ZERO_REG;
  endfunction

endpackage : regfile_pkg

// File: rtl/regfile_array.sv
// ---------------------------------------------------------------------------
// regfile_array
//   Storage for the NREG x XLEN integer register file.
//   One synchronous write port and two combinational read ports. Entry 0 is
//   never written and always reads as zero, so x0 behaves as a constant.
//   A synchronous clear zeroes every entry so no register is ever undefined
//   after reset.
//
// Ports:
//   clk      in   1     clock, all updates on the rising edge
//   clear    in   1     synchronous clear of all entries (highest priority)
//   wb       in   wb_req_t  write request: enable, index, data
//   raddr_a  in   AW    read port A index
//   raddr_b  in   AW    read port B index
//   rdata_a  out  XLEN  read port A data (combinational)
//   rdata_b  out  XLEN  read port B data (combinational)
// ---------------------------------------------------------------------------
module regfile_array
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            clear,
  input  wb_req_t         wb,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] mem [NREG];

  // NOTE: this array is cleared on reset because every architectural
  // register must be defined afterwards; a clearable array maps to
  // flip-flops rather than an SRAM macro, which is acceptable at 32 entries.
  // NOTE: sequential state uses non-blocking assignments so every reader
  // sees the pre-edge value, which gives the required read-before-write
  // behaviour between the array and the capture registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (wb.en && is_writable(wb.addr)) begin
      mem[wb.addr] <= wb.data;
    end
  end

  // x0 is forced on the read side as well, so its value never depends on
  // the contents of mem[0].
  assign rdata_a = (raddr_a == ZERO_REG) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == ZERO_REG) ? '0 : mem[raddr_b];

endmodule : regfile_array

// File: rtl/register.sv
// ---------------------------------------------------------------------------
// register
//   Integer register file for the RISC-V core, sitting between decode and
//   the execute/memory stages. Provides the write-back source mux, the
//   synchronous reset, and three registered read outputs:
//     data1 - operand A, captured from x[rs1] when wr1 is set
//     data2 - operand B, captured from x[rs2] when wr2 is set
//     data3 - store data, captured from x[rs2] when store is set
//   Captures sample the array before a same-edge write; a value written at
//   one edge becomes visible to captures from the next edge on.
//
// Ports:
//   clk     in   1     system clock, rising edge
//   reset   in   1     synchronous, active-high; clears everything
//   load    in   1     write-back source: 1 = memory, 0 = result
//   store   in   1     capture store data into data3
//   wr1     in   1     capture operand A into data1
//   wr2     in   1     capture operand B into data2
//   wr_en   in   1     register write enable
//   result  in   XLEN  ALU result for write-back
//   memory  in   XLEN  load data for write-back
//   rs1     in   AW    source register 1 index
//   rs2     in   AW    source register 2 index
//   rd      in   AW    destination register index
//   data1   out  XLEN  registered operand A
//   data2   out  XLEN  registered operand B
//   data3   out  XLEN  registered store data
// ---------------------------------------------------------------------------
module register
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            store,
  input  logic            wr1,
  input  logic            wr2,
  input  logic            wr_en,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] memory,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  output logic [XLEN-1:0] data1,
  output logic [XLEN-1:0] data2,
  output logic [XLEN-1:0] data3
);

  wb_req_t         wb;
  logic [XLEN-1:0] rdata_a;
  logic [XLEN-1:0] rdata_b;

  // Write-back request. Reset suppresses the write so a pending write in
  // the reset cycle is discarded rather than racing the clear.
  // NOTE: every field gets a default at the top of the block so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    wb      = '0;
    wb.en   = wr_en && !reset;
    wb.addr = rd;
    wb.data = load ? memory : result;
  end

  regfile_array u_array (
    .clk     (clk),
    .clear   (reset),
    .wb      (wb),
    .raddr_a (rs1),
    .raddr_b (rs2),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  // Capture registers. Each holds when its enable is low; wr2 and store
  // share read port B, so the same rs2 yields the same value in both.
  always_ff @(posedge clk) begin
    if (reset) begin
      data1 <= '0;
      data2 <= '0;
      data3 <= '0;
    end else begin
      if (wr1)   data1 <= rdata_a;
      if (wr2)   data2 <= rdata_b;
      if (store) data3 <= rdata_b;
    end
  end

endmodule : register

// File: tb/tb_register.sv
// ---------------------------------------------------------------------------
// tb_register
//   Self-checking bench for the register file. A stimulus process drives
//   one transaction per cycle, updates an array-based reference model and
//   pushes the expected data1/data2/data3 for the following edge into a
//   queue. A monitor process pops and compares after every rising edge.
// ---------------------------------------------------------------------------
module tb_register;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset, load, store, wr1, wr2, wr_en;
  logic [XLEN-1:0] result, memory;
  logic [AW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] data1, data2, data3;

  register dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .store  (store),
    .wr1    (wr1),
    .wr2    (wr2),
    .wr_en  (wr_en),
    .result (result),
    .memory (memory),
    .rs1    (rs1),
    .rs2    (rs2),
    .rd     (rd),
    .data1  (data1),
    .data2  (data2),
    .data3  (data3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    int              which;   // 1 = data1, 2 = data2, 3 = data3
    logic [XLEN-1:0] val;
    string           tag;
  } exp_t;

  exp_t            sb[$];
  int              cyc = 0;
  int              n_cmp = 0;
  int              n_bad = 0;

  // Reference model: plain architectural state.
  logic [XLEN-1:0] regs [32];
  logic [XLEN-1:0] e1, e2, e3;

  // Monitor: counts edges, then checks every expectation due this edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        logic [XLEN-1:0] act;
        e = sb.pop_front();
        case (e.which)
          1:       act = data1;
          2:       act = data2;
          default: act = data3;
        endcase
        n_cmp++;
        if (act !== e.val || e.cyc != cyc) begin
          n_bad++;
          $display("FAIL %s data%0d cycle %0d: got %h expected %h",
                   e.tag, e.which, cyc, act, e.val);
        end
      end
    end
  end

  // One transaction: drive at the falling edge, update model, queue the
  // values the outputs must show right after the next rising edge.
  task automatic step(input logic r, input logic we, input logic ld,
                      input logic w1, input logic w2, input logic st,
                      input logic [XLEN-1:0] res, input logic [XLEN-1:0] mem,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                      input logic [AW-1:0] d, input string tag);
    exp_t e;
    @(negedge clk);
    reset = r; wr_en = we; load = ld; wr1 = w1; wr2 = w2; store = st;
    result = res; memory = mem; rs1 = a1; rs2 = a2; rd = d;
    if (r) begin
      for (int i = 0; i < 32; i++) regs[i] = '0;
      e1 = '0; e2 = '0; e3 = '0;
    end else begin
      // Captures see the state before this edge's write.
      if (w1) e1 = regs[a1];
      if (w2) e2 = regs[a2];
      if (st) e3 = regs[a2];
      if (we && d != 0) regs[d] = ld ? mem : res;
    end
    e.cyc = cyc + 1; e.tag = tag;
    e.which = 1; e.val = e1; sb.push_back(e);
    e.which = 2; e.val = e2; sb.push_back(e);
    e.which = 3; e.val = e3; sb.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    e1 = '0; e2 = '0; e3 = '0;
    reset = 1'b1; load = 0; store = 0; wr1 = 0; wr2 = 0; wr_en = 0;
    result = '0; memory = '0; rs1 = '0; rs2 = '0; rd = '0;

    // Directed sequence.
    step(1, 0, 0, 0, 0, 0, '0, '0, 0, 0, 0, "reset");
    step(0, 0, 0, 1, 1, 1, '0, '0, 1, 2, 0, "idle_capture");
    step(0, 1, 1, 0, 0, 0, 32'h0, 32'h0000BFBF, 0, 0, 1, "load_wb");
    step(0, 0, 0, 1, 0, 0, '0, '0, 1, 0, 0, "read_x1");
    step(0, 1, 0, 0, 0, 0, 32'h00002267, 32'hDEAD0000, 0, 0, 2, "result_wb");
    step(0, 0, 0, 0, 1, 0, '0, '0, 0, 2, 0, "read_x2");
    step(0, 0, 0, 0, 0, 1, '0, '0, 0, 3, 0, "store_x3");
    step(0, 0, 0, 0, 1, 0, '0, '0, 0, 5, 0, "read_x5");
    step(0, 1, 0, 0, 0, 0, 32'hFFFFFFFF, '0, 0, 0, 0, "write_x0");
    step(0, 0, 0, 1, 0, 0, '0, '0, 0, 0, 0, "read_x0");
    step(0, 1, 0, 1, 0, 0, 32'h12345678, '0, 4, 0, 4, "collision");
    step(0, 0, 0, 1, 0, 0, '0, '0, 4, 0, 0, "after_collision");
    step(0, 0, 0, 0, 0, 0, '0, '0, 7, 0, 0, "hold");
    step(1, 1, 0, 1, 1, 1, 32'hCAFEF00D, '0, 4, 4, 4, "reset_mid");
    step(0, 0, 0, 1, 1, 1, '0, '0, 4, 4, 0, "x4_cleared");

    // Randomized traffic over a small index range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom, $urandom,
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
           AW'($urandom_range(0, 7)), "random");
    end

    // Let the monitor drain, bounded by a few edges.
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_register
